// File: rtl/ex_mem_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_if
// Purpose  : EX->MEM handshake and payload bundle for the ex_mem_skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_mem_skid_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              Flush_i;
    logic              InValid_i;
    logic              InReady_o;
    logic [DATA_W-1:0] AluRes_i;
    logic              Zero_i;
    logic [DATA_W-1:0] StoreData_i;
    logic [RD_W-1:0]   RdAddr_i;
    logic              RegWrite_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              Branch_i;
    logic              OutValid_o;
    logic              OutReady_i;
    logic [DATA_W-1:0] AluRes_o;
    logic [DATA_W-1:0] StoreData_o;
    logic [RD_W-1:0]   RdAddr_o;
    logic              RegWrite_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              BranchTaken_o;
    logic [1:0]        Occupancy_o;

    modport slave (
        input  Flush_i, InValid_i, AluRes_i, Zero_i, StoreData_i, RdAddr_i,
               RegWrite_i, MemRead_i, MemWrite_i, Branch_i, OutReady_i,
        output InReady_o, OutValid_o, AluRes_o, StoreData_o, RdAddr_o,
               RegWrite_o, MemRead_o, MemWrite_o, BranchTaken_o, Occupancy_o
    );

    modport master (
        output Flush_i, InValid_i, AluRes_i, Zero_i, StoreData_i, RdAddr_i,
               RegWrite_i, MemRead_i, MemWrite_i, Branch_i, OutReady_i,
        input  InReady_o, OutValid_o, AluRes_o, StoreData_o, RdAddr_o,
               RegWrite_o, MemRead_o, MemWrite_o, BranchTaken_o, Occupancy_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_skid.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid
// Purpose  : EX->MEM pipeline register as a 2-entry skid buffer with branch
//            resolution and flush.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  wire              clk_i,
    input  wire              rst_n_i,
    ex_mem_skid_if.slave     bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] store;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              br_taken;
    } payload_t;

    state_t   r_state;
    state_t   w_next_state;
    payload_t r_main;
    payload_t r_skid;
    payload_t w_in_beat;
    logic     w_in_fire;
    logic     w_out_fire;
    logic     w_load_main_in;
    logic     w_load_main_skid;
    logic     w_load_skid_in;

    // Branch outcome is resolved at capture so it travels with its beat.
    assign w_in_beat = '{
        alu:       bus.AluRes_i,
        store:     bus.StoreData_i,
        rd:        bus.RdAddr_i,
        reg_write: bus.RegWrite_i,
        mem_read:  bus.MemRead_i,
        mem_write: bus.MemWrite_i,
        br_taken:  bus.Branch_i & bus.Zero_i
    };

    assign bus.InReady_o  = (r_state != FULL);
    assign bus.OutValid_o = (r_state != EMPTY);
    assign w_in_fire      = bus.InValid_i & bus.InReady_o;
    assign w_out_fire     = bus.OutValid_o & bus.OutReady_i;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_next_state   = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_next_state   = FULL;
                    w_load_skid_in = 1'b1;
                end else if (w_out_fire) begin
                    w_next_state   = EMPTY;
                end
            end
            FULL: begin
                if (w_out_fire) begin
                    w_next_state     = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_next_state = EMPTY;
        endcase
        // Flush discards any incoming beat; payload registers keep stale data.
        if (bus.Flush_i) begin
            w_next_state     = EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_main_in) begin
                r_main <= w_in_beat;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid_in) begin
                r_skid <= w_in_beat;
            end
        end
    end

    assign bus.AluRes_o      = r_main.alu;
    assign bus.StoreData_o   = r_main.store;
    assign bus.RdAddr_o      = r_main.rd;
    assign bus.RegWrite_o    = r_main.reg_write & bus.OutValid_o;
    assign bus.MemRead_o     = r_main.mem_read  & bus.OutValid_o;
    assign bus.MemWrite_o    = r_main.mem_write & bus.OutValid_o;
    assign bus.BranchTaken_o = r_main.br_taken  & bus.OutValid_o;
    assign bus.Occupancy_o   = r_state;
endmodule
`default_nettype wire
